// File: rtl/quad_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : quad_input_conditioner
// Description : Quadrature encoder front end. Synchronises the raw A/B pins,
//               rejects glitches shorter than FILT_LEN clk cycles, and drives
//               clean A/B levels to the encoder counter. Also decodes a
//               per-step pulse, step direction and illegal-transition errors
//               (both channels accepted in one cycle) with a saturating count.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               a_raw      - encoder channel A pin (asynchronous)
//               b_raw      - encoder channel B pin (asynchronous)
//               err_clr    - synchronous clear of err_cnt
//               a_clean    - filtered A level
//               b_clean    - filtered B level
//               step       - 1-cycle pulse per legal quadrature transition
//               dir        - direction of last legal step, 1 = A leads B
//               err_pulse  - 1-cycle pulse when A and B accepted together
//               err_cnt    - saturating count of err_pulse events
// Revision    : 1.0 - initial release
// ============================================================================
module quad_input_conditioner #(
    parameter int FILT_LEN = 50,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_raw,
    input  logic             b_raw,
    input  logic             err_clr,
    output logic             a_clean,
    output logic             b_clean,
    output logic             step,
    output logic             dir,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);
    localparam int ST_W  = $clog2(FILT_LEN + 2);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILT_LEN - 1);
    localparam logic [ST_W-1:0]  c_st_last  = ST_W'(FILT_LEN + 1);
    localparam logic [ERR_W-1:0] c_err_max  = {ERR_W{1'b1}};

    // Channel index: bit 1 = A, bit 0 = B throughout.
    logic [1:0]            meta_q;
    logic [1:0]            sync_q;
    logic [1:0]            clean_q,    clean_d;
    logic [1:0][CNT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [1:0]            w_acc;
    logic [ST_W-1:0]       start_cnt_q, start_cnt_d;
    logic                  armed_q,    armed_d;
    logic                  step_q,     step_d;
    logic                  dir_q,      dir_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]      err_cnt_q,  err_cnt_d;

    // ------------------------------------------------------------------
    // Startup window: FILT_LEN+2 cycles after reset release during which
    // the outputs simply track the synchronised pins, so the filter does
    // not treat the power-up level as a transition.
    // ------------------------------------------------------------------
    always_comb begin
        start_cnt_d = start_cnt_q;
        armed_d     = armed_q;
        if (!armed_q) begin
            if (start_cnt_q == c_st_last) begin
                armed_d = 1'b1;
            end else begin
                start_cnt_d = start_cnt_q + ST_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel persistence filter. A level is accepted after FILT_LEN
    // consecutive cycles of disagreement with the current clean level.
    // ------------------------------------------------------------------
    always_comb begin
        clean_d    = clean_q;
        filt_cnt_d = filt_cnt_q;
        w_acc      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (!armed_q) begin
                clean_d[i]    = sync_q[i];
                filt_cnt_d[i] = '0;
            end else if (sync_q[i] == clean_q[i]) begin
                filt_cnt_d[i] = '0;
            end else if (filt_cnt_q[i] == c_cnt_last) begin
                w_acc[i]      = 1'b1;
                clean_d[i]    = sync_q[i];
                filt_cnt_d[i] = '0;
            end else begin
                filt_cnt_d[i] = filt_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transition decode on accepted changes. Forward cycle is
    // 00->10->11->01->00 ({A,B}). When only A moves the step is forward
    // if new A differs from B; when only B moves it is forward if new B
    // equals A. w_acc is only ever set once armed.
    // ------------------------------------------------------------------
    always_comb begin
        step_d      = 1'b0;
        err_pulse_d = 1'b0;
        dir_d       = dir_q;
        if (w_acc == 2'b11) begin
            err_pulse_d = 1'b1;
        end else if (w_acc[1]) begin
            step_d = 1'b1;
            dir_d  = (clean_d[1] != clean_q[0]);
        end else if (w_acc[0]) begin
            step_d = 1'b1;
            dir_d  = (clean_d[0] == clean_q[1]);
        end
    end

    // Counts the registered error pulse; a clear in the same cycle wins.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_pulse_q && (err_cnt_q != c_err_max)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q      <= 2'b00;
            sync_q      <= 2'b00;
            clean_q     <= 2'b00;
            filt_cnt_q  <= '0;
            start_cnt_q <= '0;
            armed_q     <= 1'b0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            meta_q      <= {a_raw, b_raw};
            sync_q      <= meta_q;
            clean_q     <= clean_d;
            filt_cnt_q  <= filt_cnt_d;
            start_cnt_q <= start_cnt_d;
            armed_q     <= armed_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign a_clean   = clean_q[1];
    assign b_clean   = clean_q[0];
    assign step      = step_q;
    assign dir       = dir_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_input_conditioner
// Description : Directed self-checking bench for quad_input_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_input_conditioner;

    localparam int FILT_LEN = 50;
    localparam int ERR_W    = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             a_raw;
    logic             b_raw;
    logic             err_clr;
    logic             a_clean;
    logic             b_clean;
    logic             step;
    logic             dir;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int step_seen = 0;
    int errp_seen = 0;
    int a_hi_seen = 0;

    quad_input_conditioner #(
        .FILT_LEN (FILT_LEN),
        .ERR_W    (ERR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_raw     (a_raw),
        .b_raw     (b_raw),
        .err_clr   (err_clr),
        .a_clean   (a_clean),
        .b_clean   (b_clean),
        .step      (step),
        .dir       (dir),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Event monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (step === 1'b1)      step_seen = step_seen + 1;
        if (err_pulse === 1'b1) errp_seen = errp_seen + 1;
        if (a_clean === 1'b1)   a_hi_seen = a_hi_seen + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for the clean outputs to reach {ea,eb}; lat=-1 on timeout.
    task automatic wait_clean(input logic ea, input logic eb, input int maxc, output int lat);
        bit found;
        found = 1'b0;
        lat   = -1;
        for (int i = 1; i <= maxc; i++) begin
            if (!found) begin
                tick(1);
                if (a_clean === ea && b_clean === eb) begin
                    found = 1'b1;
                    lat   = i;
                end
            end
        end
    endtask

    task automatic test_reset;
        int s0, e0;
        reset_n = 1'b0;
        a_raw   = 1'b1;
        b_raw   = 1'b1;
        err_clr = 1'b0;
        tick(3);
        checks++; if (a_clean !== 1'b0) begin errors++; $display("FAIL reset_a_clean: got %b expected 0", a_clean); end
        checks++; if (b_clean !== 1'b0) begin errors++; $display("FAIL reset_b_clean: got %b expected 0", b_clean); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", dir); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b expected 0", err_pulse); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        reset_n = 1'b1;
        s0 = step_seen;
        e0 = errp_seen;
        // Two sync flops then a direct load during the unarmed window.
        tick(5);
        checks++; if ({a_clean, b_clean} !== 2'b11) begin errors++; $display("FAIL startup_load: got %b expected 11", {a_clean, b_clean}); end
        tick(FILT_LEN + 2 - 5);
        checks++; if ({a_clean, b_clean} !== 2'b11) begin errors++; $display("FAIL startup_clean: got %b expected 11", {a_clean, b_clean}); end
        checks++; if (step_seen - s0 != 0) begin errors++; $display("FAIL startup_steps: got %0d expected 0", step_seen - s0); end
        checks++; if (errp_seen - e0 != 0) begin errors++; $display("FAIL startup_errs: got %0d expected 0", errp_seen - e0); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL startup_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    // Walks one full quadrature cycle from state 00.
    task automatic test_sequence(input logic fwd);
        logic [1:0] seq [4];
        int lat, s0;
        if (fwd) begin
            seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        end else begin
            seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        end
        s0 = step_seen;
        for (int k = 0; k < 4; k++) begin
            a_raw = seq[k][1];
            b_raw = seq[k][0];
            wait_clean(seq[k][1], seq[k][0], FILT_LEN + 10, lat);
            checks++; if (lat < FILT_LEN + 1 || lat > FILT_LEN + 3) begin errors++; $display("FAIL seq_latency dir=%b step %0d: got %0d expected %0d+/-1", fwd, k, lat, FILT_LEN + 2); end
            checks++; if (step !== 1'b1) begin errors++; $display("FAIL seq_step_with_change dir=%b step %0d: got %b expected 1", fwd, k, step); end
            checks++; if (dir !== fwd) begin errors++; $display("FAIL seq_dir step %0d: got %b expected %b", k, dir, fwd); end
            tick(200 - lat);
        end
        checks++; if (step_seen - s0 != 4) begin errors++; $display("FAIL seq_step_count dir=%b: got %0d expected 4", fwd, step_seen - s0); end
    endtask

    task automatic test_glitch;
        int s0, h0;
        s0 = step_seen;
        h0 = a_hi_seen;
        a_raw = 1'b1;
        tick(FILT_LEN - 1);
        a_raw = 1'b0;
        tick(150);
        checks++; if (a_clean !== 1'b0) begin errors++; $display("FAIL glitch49_a_clean: got %b expected 0", a_clean); end
        checks++; if (a_hi_seen - h0 != 0) begin errors++; $display("FAIL glitch49_a_high_cycles: got %0d expected 0", a_hi_seen - h0); end
        checks++; if (step_seen - s0 != 0) begin errors++; $display("FAIL glitch49_steps: got %0d expected 0", step_seen - s0); end
        s0 = step_seen;
        h0 = a_hi_seen;
        a_raw = 1'b1;
        tick(FILT_LEN);
        a_raw = 1'b0;
        tick(150);
        checks++; if (a_hi_seen - h0 != FILT_LEN) begin errors++; $display("FAIL glitch50_a_high_cycles: got %0d expected %0d", a_hi_seen - h0, FILT_LEN); end
        checks++; if (step_seen - s0 != 2) begin errors++; $display("FAIL glitch50_steps: got %0d expected 2", step_seen - s0); end
        checks++; if (a_clean !== 1'b0) begin errors++; $display("FAIL glitch50_a_clean_end: got %b expected 0", a_clean); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL glitch50_dir: got %b expected 0", dir); end
    endtask

    task automatic test_error;
        int s0, e0;
        bit found;
        s0 = step_seen;
        e0 = errp_seen;
        a_raw = 1'b1;
        b_raw = 1'b1;
        tick(100);
        checks++; if (errp_seen - e0 != 1) begin errors++; $display("FAIL err_single_pulses: got %0d expected 1", errp_seen - e0); end
        checks++; if (step_seen - s0 != 0) begin errors++; $display("FAIL err_single_steps: got %0d expected 0", step_seen - s0); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_single_cnt: got %0d expected 1", err_cnt); end
        checks++; if ({a_clean, b_clean} !== 2'b11) begin errors++; $display("FAIL err_single_clean: got %b expected 11", {a_clean, b_clean}); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL err_single_dir_held: got %b expected 0", dir); end
        for (int i = 0; i < 300; i++) begin
            a_raw = ~a_raw;
            b_raw = ~b_raw;
            tick(100);
        end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_saturate_cnt: got %0d expected 255", err_cnt); end
        checks++; if (errp_seen - e0 != 301) begin errors++; $display("FAIL err_saturate_pulses: got %0d expected 301", errp_seen - e0); end
        checks++; if (step_seen - s0 != 0) begin errors++; $display("FAIL err_saturate_steps: got %0d expected 0", step_seen - s0); end
        // Clear asserted in the very cycle the error pulse is visible.
        a_raw = ~a_raw;
        b_raw = ~b_raw;
        found = 1'b0;
        for (int i = 0; i < FILT_LEN + 10; i++) begin
            if (!found) begin
                tick(1);
                if (err_pulse === 1'b1) found = 1'b1;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL err_clr_wait_pulse: got timeout expected err_pulse"); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_clr_coincident: got %0d expected 0", err_cnt); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", err_pulse); end
        tick(50);
    endtask

    task automatic test_midreset;
        int s0, e0;
        a_raw = 1'b1;
        b_raw = 1'b0;
        tick(200);
        checks++; if ({a_clean, b_clean, dir} !== 3'b101) begin errors++; $display("FAIL midreset_pre: got %b expected 101", {a_clean, b_clean, dir}); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({a_clean, b_clean, step, dir, err_pulse} !== 5'b00000 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL midreset_async_outputs: got %b cnt %0d expected 00000 cnt 0", {a_clean, b_clean, step, dir, err_pulse}, err_cnt);
        end
        tick(3);
        reset_n = 1'b1;
        s0 = step_seen;
        e0 = errp_seen;
        tick(FILT_LEN + 12);
        checks++; if ({a_clean, b_clean} !== 2'b10) begin errors++; $display("FAIL midreset_recover: got %b expected 10", {a_clean, b_clean}); end
        checks++; if (step_seen - s0 != 0) begin errors++; $display("FAIL midreset_steps: got %0d expected 0", step_seen - s0); end
        checks++; if (errp_seen - e0 != 0) begin errors++; $display("FAIL midreset_errs: got %0d expected 0", errp_seen - e0); end
    endtask

    initial begin
        test_reset();
        // Move from 11 to 00 (two forward steps) before the sequence tests.
        a_raw = 1'b0;
        tick(200);
        b_raw = 1'b0;
        tick(200);
        test_sequence(1'b1);
        test_sequence(1'b0);
        test_glitch();
        test_error();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
